// File: rtl/fcmp_scheduler_if.sv
// Request/response bundle between FP register-file read ports, the compare scheduler
// and the response consumer.
interface fcmp_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) ();
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [2*NREQ-1:0]  req_op;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_data;
  logic               rsp_err;

  // master: requesters plus response consumer; slave: the scheduler
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/fcmp_scheduler.sv
// Round-robin scheduler sharing one combinational FP compare unit (EQ/LT/LE)
// among NREQ requesters, one operation in flight at a time.
module fcmp_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  fcmp_scheduler_if.slave     bus,
  output logic [31:0]         cmp_a,
  output logic [31:0]         cmp_b,
  output logic                cmp_eq_en,
  output logic                cmp_lt_en,
  output logic                cmp_le_en,
  input  logic [31:0]         cmp_result,
  output logic                busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [1:0] OP_EQ  = 2'b00;
  localparam logic [1:0] OP_LT  = 2'b01;
  localparam logic [1:0] OP_LE  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic [1:0]     op_q;

  logic           grant_found;
  int             grant_int;
  int             k;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] ptr_next;

  // First set req_valid bit at or above ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_int   = 0;
    k           = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!grant_found && bus.req_valid[k]) begin
        grant_found = 1'b1;
        grant_int   = k;
      end
    end
  end

  assign grant_idx = IDW'(grant_int);
  assign ptr_next  = (grant_int == NREQ - 1) ? '0 : IDW'(grant_int + 1);

  // NOTE: req_ready is also qualified with rst so it reads zero while reset is held,
  // even though the FSM already sits in IDLE and a request may be pending.
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && grant_found && !rst) bus.req_ready[grant_int] = 1'b1;
  end

  assign cmp_eq_en     = (state == ISSUE) && (op_q == OP_EQ);
  assign cmp_lt_en     = (state == ISSUE) && (op_q == OP_LT);
  assign cmp_le_en     = (state == ISSUE) && (op_q == OP_LE);
  assign bus.rsp_valid = (state == RESP);
  assign busy          = (state != IDLE);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; cmp_a/cmp_b double as the latched operands and hold between issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      op_q         <= OP_EQ;
      cmp_a        <= '0;
      cmp_b        <= '0;
      bus.rsp_id   <= '0;
      bus.rsp_data <= '0;
      bus.rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            cmp_a      <= bus.req_a[grant_int*32 +: 32];
            cmp_b      <= bus.req_b[grant_int*32 +: 32];
            op_q       <= bus.req_op[grant_int*2 +: 2];
            bus.rsp_id <= grant_idx;
            ptr        <= ptr_next;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          bus.rsp_data <= (op_q == OP_ILL) ? 32'h0 : cmp_result;
          bus.rsp_err  <= (op_q == OP_ILL);
          state        <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fcmp_scheduler.sv
// Directed bench for fcmp_scheduler: reset values, round-robin order, a vector
// table of single operations, backpressure and reset during ISSUE/RESP.
module tb_fcmp_scheduler;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmp_a, cmp_b, cmp_result;
  logic        cmp_eq_en, cmp_lt_en, cmp_le_en, busy;

  int pass_cnt  = 0;
  int check_cnt = 0;

  fcmp_scheduler_if #(.NREQ(NREQ)) bus ();

  fcmp_scheduler #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cmp_a      (cmp_a),
    .cmp_b      (cmp_b),
    .cmp_eq_en  (cmp_eq_en),
    .cmp_lt_en  (cmp_lt_en),
    .cmp_le_en  (cmp_le_en),
    .cmp_result (cmp_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Compare-unit model: ordered key for non-NaN singles, +0 == -0.
  function automatic logic [31:0] fkey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic f_eq(input logic [31:0] a, input logic [31:0] b);
    return (a == b) || ((a[30:0] == 31'h0) && (b[30:0] == 31'h0));
  endfunction

  function automatic logic f_lt(input logic [31:0] a, input logic [31:0] b);
    return !f_eq(a, b) && (fkey(a) < fkey(b));
  endfunction

  // Garbage when no enable is set, so an illegal op that leaks cmp_result shows up.
  always_comb begin
    cmp_result = 32'hA5A5_A5A5;
    if (cmp_eq_en)      cmp_result = {31'h0, f_eq(cmp_a, cmp_b)};
    else if (cmp_lt_en) cmp_result = {31'h0, f_lt(cmp_a, cmp_b)};
    else if (cmp_le_en) cmp_result = {31'h0, f_eq(cmp_a, cmp_b) || f_lt(cmp_a, cmp_b)};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'h0);
    check({tag, " cmp_a"},     cmp_a, 32'h0);
    check({tag, " cmp_b"},     cmp_b, 32'h0);
    check({tag, " en"},        {29'h0, cmp_eq_en, cmp_lt_en, cmp_le_en}, 32'h0);
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    check({tag, " rsp_id"},    32'(bus.rsp_id), 32'h0);
    check({tag, " rsp_data"},  bus.rsp_data, 32'h0);
    check({tag, " rsp_err"},   32'(bus.rsp_err), 32'h0);
    check({tag, " busy"},      32'(busy), 32'h0);
  endtask

  task automatic set_req(input int idx, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_op[idx*2 +: 2]  = op;
    bus.req_a[idx*32 +: 32] = a;
    bus.req_b[idx*32 +: 32] = b;
  endtask

  typedef struct {
    int          idx;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [2:0]  exp_en;   // {eq, lt, le}
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 2'b00, 32'h3F80_0000, 32'h3F80_0000, 32'h1, 1'b0, 3'b100};
    vecs[1] = '{1, 2'b01, 32'hBF80_0000, 32'h3F80_0000, 32'h1, 1'b0, 3'b010};
    vecs[2] = '{3, 2'b10, 32'h4000_0000, 32'h3F80_0000, 32'h0, 1'b0, 3'b001};
    vecs[3] = '{2, 2'b11, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 1'b1, 3'b000};
    vecs[4] = '{1, 2'b00, 32'h0000_0000, 32'h8000_0000, 32'h1, 1'b0, 3'b100};
    vecs[5] = '{0, 2'b01, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 1'b0, 3'b010};
    vecs[6] = '{2, 2'b10, 32'hC000_0000, 32'hC000_0000, 32'h1, 1'b0, 3'b001};

    // Reset with every requester pending: nothing may be granted.
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'hF;
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b00, 32'(i + 1), 32'(i + 1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");

    // Round robin with all four valid: grants 0,1,2,3,0 every 3 cycles.
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      check("rr grant", 32'(bus.req_ready), 32'(1 << (g % NREQ)));
      @(negedge clk);
      check("rr issue ready", 32'(bus.req_ready), 32'h0);
      check("rr cmp_a", cmp_a, 32'((g % NREQ) + 1));
      @(negedge clk);
      check("rr rsp_valid", 32'(bus.rsp_valid), 32'h1);
      check("rr rsp_id", 32'(bus.rsp_id), 32'(g % NREQ));
    end
    @(posedge clk); #1;
    bus.req_valid = '0;

    // Vector table: one request at a time, full transaction per record.
    foreach (vecs[n]) begin
      @(posedge clk); #1;
      set_req(vecs[n].idx, vecs[n].op, vecs[n].a, vecs[n].b);
      bus.req_valid = 4'(1 << vecs[n].idx);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("vec grant", 32'(bus.req_ready), 32'(1 << vecs[n].idx));
      check("vec idle busy", 32'(busy), 32'h0);
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(negedge clk);
      check("vec issue en", {29'h0, cmp_eq_en, cmp_lt_en, cmp_le_en}, {29'h0, vecs[n].exp_en});
      check("vec cmp_a", cmp_a, vecs[n].a);
      check("vec cmp_b", cmp_b, vecs[n].b);
      check("vec issue busy", 32'(busy), 32'h1);
      @(negedge clk);
      check("vec rsp_valid", 32'(bus.rsp_valid), 32'h1);
      check("vec rsp_id", 32'(bus.rsp_id), 32'(vecs[n].idx));
      check("vec rsp_data", bus.rsp_data, vecs[n].exp_data);
      check("vec rsp_err", 32'(bus.rsp_err), 32'(vecs[n].exp_err));
      check("vec resp en", {29'h0, cmp_eq_en, cmp_lt_en, cmp_le_en}, 32'h0);
      check("vec cmp_a hold", cmp_a, vecs[n].a);
      @(negedge clk);
      check("vec after rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check("vec after busy", 32'(busy), 32'h0);
    end

    // Backpressure: requester 1 held in RESP for 5 cycles while 3 waits.
    @(posedge clk); #1;
    set_req(1, 2'b00, 32'h4049_0FDB, 32'h4049_0FDB);
    set_req(3, 2'b01, 32'h3F80_0000, 32'h4000_0000);
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("bp grant", 32'(bus.req_ready), 32'h2);
    @(posedge clk); #1;
    bus.req_valid = 4'b1000;
    @(negedge clk);
    check("bp issue ready", 32'(bus.req_ready), 32'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp rsp_valid", 32'(bus.rsp_valid), 32'h1);
      check("bp rsp_id", 32'(bus.rsp_id), 32'h1);
      check("bp rsp_data", bus.rsp_data, 32'h1);
      check("bp rsp_err", 32'(bus.rsp_err), 32'h0);
      check("bp req_ready", 32'(bus.req_ready), 32'h0);
      check("bp busy", 32'(busy), 32'h1);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp handshake valid", 32'(bus.rsp_valid), 32'h1);
    @(negedge clk);
    check("bp idle valid", 32'(bus.rsp_valid), 32'h0);
    check("bp idle busy", 32'(busy), 32'h0);
    check("bp next grant", 32'(bus.req_ready), 32'h8);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    check("bp r3 lt_en", 32'(cmp_lt_en), 32'h1);
    @(negedge clk);
    check("bp r3 rsp_id", 32'(bus.rsp_id), 32'h3);
    check("bp r3 rsp_data", bus.rsp_data, 32'h1);
    repeat (2) @(posedge clk);
    #1;

    // Reset during ISSUE: stale ptr would grant 3 first, reset ptr grants 1.
    set_req(2, 2'b01, 32'hC120_0000, 32'h4120_0000);
    bus.req_valid = 4'b0100;
    @(negedge clk);
    check("rst1 grant", 32'(bus.req_ready), 32'h4);
    @(posedge clk); #1;
    bus.req_valid = 4'b1010;
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst issue");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("rst1 regrant", 32'(bus.req_ready), 32'h2);
    check("rst1 no rsp", 32'(bus.rsp_valid), 32'h0);

    // Reset during RESP: stale ptr would grant 2 first, reset ptr grants 1.
    @(posedge clk); #1;
    bus.req_valid = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    check("rst2 in resp", 32'(bus.rsp_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst resp");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid = 4'b0110;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("rst2 regrant", 32'(bus.req_ready), 32'h2);
    check("rst2 no rsp", 32'(bus.rsp_valid), 32'h0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst2 rsp_id", 32'(bus.rsp_id), 32'h1);
    check("rst2 rsp_valid", 32'(bus.rsp_valid), 32'h1);
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
